// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Sits upstream of the fetch PC register. For every fetch PC it
// combinationally supplies the predicted next PC. It is trained by the EX stage
// with each resolved branch or JAL. It also keeps saturating debug counters for
// resolved branches and mispredictions.
//
// Ports
//   clk             pipeline clock, all state changes on posedge
//   reset           synchronous, active-high; has priority over updates
//   PC_FE           current fetch PC
//   pcpred_FE       predicted next fetch PC (combinational from PC_FE)
//   predtaken_FE    1 = BTB hit with a taken-leaning counter
//   upd_valid_EX    EX resolved a branch/JAL this cycle
//   upd_pc_EX       PC of the resolved instruction
//   upd_isjmp_EX    resolved instruction is a JAL
//   upd_taken_EX    actual direction
//   upd_target_EX   actual target when taken
//   upd_mispred_EX  EX flagged a misprediction for this instruction
//   brcount         saturating count of resolved branches/JALs
//   mispredcount    saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int          DBITS     = 32,
  parameter logic [31:0] INSTSIZE  = 32'd4,
  parameter int          INDEXBITS = 4,
  parameter int          TAGBITS   = 10,
  parameter int          STATBITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    PC_FE,
  output logic [DBITS-1:0]    pcpred_FE,
  output logic                predtaken_FE,
  input  logic                upd_valid_EX,
  input  logic [DBITS-1:0]    upd_pc_EX,
  input  logic                upd_isjmp_EX,
  input  logic                upd_taken_EX,
  input  logic [DBITS-1:0]    upd_target_EX,
  input  logic                upd_mispred_EX,
  output logic [STATBITS-1:0] brcount,
  output logic [STATBITS-1:0] mispredcount
);

  localparam int ENTRIES = 1 << INDEXBITS;
  localparam int IDX_LO  = 2;
  localparam int IDX_HI  = INDEXBITS + 1;
  localparam int TAG_LO  = INDEXBITS + 2;
  localparam int TAG_HI  = INDEXBITS + TAGBITS + 1;

  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken for a new branch

  // BTB storage
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAGBITS-1:0] tag_q    [ENTRIES];
  logic [DBITS-1:0]   target_q [ENTRIES];

  // Statistics
  logic [STATBITS-1:0] brcount_q, brcount_d;
  logic [STATBITS-1:0] mispred_q, mispred_d;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup (zero latency, sees pre-update contents)
  // ---------------------------------------------------------------------------
  logic [INDEXBITS-1:0] fe_idx;
  logic [TAGBITS-1:0]   fe_tag;
  logic                 fe_hit;

  assign fe_idx       = PC_FE[IDX_HI:IDX_LO];
  assign fe_tag       = PC_FE[TAG_HI:TAG_LO];
  assign fe_hit       = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);
  assign predtaken_FE = fe_hit && ctr_q[fe_idx][1];
  assign pcpred_FE    = predtaken_FE ? target_q[fe_idx]
                                     : PC_FE + DBITS'(INSTSIZE);

  // ---------------------------------------------------------------------------
  // EX-side training decision
  // ---------------------------------------------------------------------------
  logic [INDEXBITS-1:0] upd_idx;
  logic [TAGBITS-1:0]   upd_tag;
  logic                 upd_hit;
  logic                 upd_taken;
  logic                 upd_alloc;       // claim the entry for upd_tag
  logic                 upd_wr_ctr;      // write upd_ctr_d into the entry
  logic                 upd_wr_target;   // write upd_target_EX into the entry
  logic [1:0]           upd_ctr_cur;
  logic [1:0]           upd_ctr_d;

  assign upd_idx     = upd_pc_EX[IDX_HI:IDX_LO];
  assign upd_tag     = upd_pc_EX[TAG_HI:TAG_LO];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];
  // A JAL is always taken, even if EX happens to leave the direction bit low.
  assign upd_taken   = upd_taken_EX || upd_isjmp_EX;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    upd_alloc     = 1'b0;
    upd_wr_ctr    = 1'b0;
    upd_wr_target = 1'b0;
    upd_ctr_d     = upd_ctr_cur;
    if (upd_valid_EX) begin
      if (upd_hit) begin
        upd_wr_ctr = 1'b1;
        if (upd_isjmp_EX) begin
          upd_ctr_d     = CTR_MAX;
          upd_wr_target = 1'b1;
        end else if (upd_taken) begin
          upd_ctr_d     = (upd_ctr_cur == CTR_MAX) ? CTR_MAX : upd_ctr_cur + 2'd1;
          upd_wr_target = 1'b1;
        end else begin
          upd_ctr_d     = (upd_ctr_cur == CTR_MIN) ? CTR_MIN : upd_ctr_cur - 2'd1;
        end
      end else if (upd_taken) begin
        // Miss with a taken outcome evicts whatever aliases to this index.
        upd_alloc     = 1'b1;
        upd_wr_ctr    = 1'b1;
        upd_wr_target = 1'b1;
        upd_ctr_d     = upd_isjmp_EX ? CTR_MAX : CTR_ALLOC;
      end
    end
  end

  // Saturating statistics counters
  always_comb begin
    brcount_d = brcount_q;
    mispred_d = mispred_q;
    if (upd_valid_EX && (brcount_q != '1)) begin
      brcount_d = brcount_q + STATBITS'(1);
    end
    if (upd_valid_EX && upd_mispred_EX && (mispred_q != '1)) begin
      mispred_d = mispred_q + STATBITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_MIN;
      end
      brcount_q <= '0;
      mispred_q <= '0;
    end else begin
      if (upd_alloc) begin
        valid_q[upd_idx] <= 1'b1;
      end
      if (upd_wr_ctr) begin
        ctr_q[upd_idx] <= upd_ctr_d;
      end
      brcount_q <= brcount_d;
      mispred_q <= mispred_d;
    end
  end

  // NOTE: tag and target arrays are deliberately left out of reset. A cleared
  // valid bit already hides them, and keeping them reset-free lets them map to
  // plain storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (upd_alloc) begin
        tag_q[upd_idx] <= upd_tag;
      end
      if (upd_wr_target) begin
        target_q[upd_idx] <= upd_target_EX;
      end
    end
  end

  assign brcount      = brcount_q;
  assign mispredcount = mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for branch_target_predictor. Expected lookup results and
// counter values are pushed to a scoreboard when stimulus is driven, then
// popped and compared when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] PC_FE;
  logic [31:0] pcpred_FE;
  logic        predtaken_FE;
  logic        upd_valid_EX;
  logic [31:0] upd_pc_EX;
  logic        upd_isjmp_EX;
  logic        upd_taken_EX;
  logic [31:0] upd_target_EX;
  logic        upd_mispred_EX;
  logic [15:0] brcount;
  logic [15:0] mispredcount;

  branch_target_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .PC_FE          (PC_FE),
    .pcpred_FE      (pcpred_FE),
    .predtaken_FE   (predtaken_FE),
    .upd_valid_EX   (upd_valid_EX),
    .upd_pc_EX      (upd_pc_EX),
    .upd_isjmp_EX   (upd_isjmp_EX),
    .upd_taken_EX   (upd_taken_EX),
    .upd_target_EX  (upd_target_EX),
    .upd_mispred_EX (upd_mispred_EX),
    .brcount        (brcount),
    .mispredcount   (mispredcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pred;
    logic        taken;
    logic [15:0] br;
    logic [15:0] mis;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_br  = '0;
  logic [15:0] exp_mis = '0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Present one resolved instruction for exactly one posedge; returns at the
  // following negedge with the model counters updated.
  task automatic do_update(input logic [31:0] pc, input logic isjmp,
                           input logic taken, input logic [31:0] tgt,
                           input logic mis);
    @(negedge clk);
    upd_valid_EX   = 1'b1;
    upd_pc_EX      = pc;
    upd_isjmp_EX   = isjmp;
    upd_taken_EX   = taken;
    upd_target_EX  = tgt;
    upd_mispred_EX = mis;
    @(negedge clk);
    upd_valid_EX   = 1'b0;
    upd_mispred_EX = 1'b0;
    exp_br = sat_inc(exp_br);
    if (mis) exp_mis = sat_inc(exp_mis);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    upd_valid_EX = 1'b0; upd_pc_EX = '0; upd_isjmp_EX = 1'b0;
    upd_taken_EX = 1'b0; upd_target_EX = '0; upd_mispred_EX = 1'b0;
    PC_FE = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_br = '0; exp_mis = '0;

    PC_FE = 32'h100; sb_q.push_back('{32'h104, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL reset_lookup: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end

    PC_FE = 32'hFFFF_FFFC; sb_q.push_back('{32'h0, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end
  endtask

  task automatic test_train;
    do_update(32'h108, 1'b0, 1'b1, 32'h140, 1'b1);
    PC_FE = 32'h108; sb_q.push_back('{32'h140, 1'b1, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL train_alloc: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end
  endtask

  // Counter walk for the entry at 0x108 (starts at 10). Each step gives the
  // update direction and the prediction expected afterwards.
  task automatic test_counter;
    logic        dir  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] pred [9] = '{32'h10C, 32'h10C, 32'h10C, 32'h140, 32'h140,
                              32'h140, 32'h140, 32'h10C, 32'h140};
    for (int i = 0; i < 9; i++) begin
      do_update(32'h108, 1'b0, dir[i], 32'h140, 1'(i % 2));
      PC_FE = 32'h108;
      sb_q.push_back('{pred[i], (pred[i] == 32'h140), exp_br, exp_mis}); #1;
      e = sb_q.pop_front(); n_tests++;
      if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
        n_fail++;
        $display("FAIL counter_step%0d: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
                 i, pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
      end
    end
  endtask

  task automatic test_alias;
    do_update(32'h108, 1'b0, 1'b1, 32'h140, 1'b0);
    do_update(32'h148, 1'b0, 1'b1, 32'h200, 1'b1);
    do_update(32'h108, 1'b0, 1'b0, 32'h0,   1'b0);  // miss, not taken: no change

    PC_FE = 32'h108; sb_q.push_back('{32'h10C, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL alias_evicted: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end

    PC_FE = 32'h148; sb_q.push_back('{32'h200, 1'b1, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL alias_owner: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    PC_FE = 32'h110;
    upd_valid_EX = 1'b1; upd_pc_EX = 32'h110; upd_isjmp_EX = 1'b0;
    upd_taken_EX = 1'b1; upd_target_EX = 32'h300; upd_mispred_EX = 1'b1;
    sb_q.push_back('{32'h114, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL same_cycle_pre: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end
    @(negedge clk);
    upd_valid_EX = 1'b0; upd_mispred_EX = 1'b0;
    exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis);
    sb_q.push_back('{32'h300, 1'b1, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL same_cycle_post: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end

    // Branch allocates weakly taken: one not-taken drops it below threshold.
    do_update(32'h110, 1'b0, 1'b0, 32'h0, 1'b1);
    PC_FE = 32'h110; sb_q.push_back('{32'h114, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL branch_alloc_ctr: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end

    // JAL allocates strongly taken: one not-taken still predicts taken.
    do_update(32'h120, 1'b1, 1'b1, 32'h400, 1'b1);
    PC_FE = 32'h120; sb_q.push_back('{32'h400, 1'b1, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL jal_alloc: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end
    do_update(32'h120, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.push_back('{32'h400, 1'b1, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL jal_ctr_strong: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end
  endtask

  task automatic test_stats;
    // mispred without valid must not count
    @(negedge clk);
    upd_mispred_EX = 1'b1;
    @(negedge clk);
    upd_mispred_EX = 1'b0;
    sb_q.push_back('{32'h0, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({brcount, mispredcount} !== {e.br, e.mis}) begin
      n_fail++;
      $display("FAIL mispred_no_valid: got br=%0d mis=%0d, want br=%0d mis=%0d",
               brcount, mispredcount, e.br, e.mis);
    end

    // Not-taken updates to an empty index: counters move, BTB untouched.
    @(negedge clk);
    upd_valid_EX = 1'b1; upd_pc_EX = 32'h1000; upd_isjmp_EX = 1'b0;
    upd_taken_EX = 1'b0; upd_target_EX = 32'h0; upd_mispred_EX = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis);
    end
    upd_valid_EX = 1'b0; upd_mispred_EX = 1'b0;
    sb_q.push_back('{32'h0, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({brcount, mispredcount} !== {e.br, e.mis} || e.br !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_saturate: got br=%h mis=%h, want br=%h mis=%h",
               brcount, mispredcount, e.br, e.mis);
    end
  endtask

  task automatic test_reset_with_update;
    @(negedge clk);
    reset = 1'b1;
    upd_valid_EX = 1'b1; upd_pc_EX = 32'h1F0; upd_isjmp_EX = 1'b0;
    upd_taken_EX = 1'b1; upd_target_EX = 32'h500; upd_mispred_EX = 1'b1;
    @(negedge clk);
    reset = 1'b0; upd_valid_EX = 1'b0; upd_mispred_EX = 1'b0;
    exp_br = '0; exp_mis = '0;

    PC_FE = 32'h1F0; sb_q.push_back('{32'h1F4, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE, brcount, mispredcount} !== {e.pred, e.taken, e.br, e.mis}) begin
      n_fail++;
      $display("FAIL reset_drops_update: got %h/%b br=%0d mis=%0d, want %h/%b br=%0d mis=%0d",
               pcpred_FE, predtaken_FE, brcount, mispredcount, e.pred, e.taken, e.br, e.mis);
    end

    PC_FE = 32'h120; sb_q.push_back('{32'h124, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL reset_clears_jal: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end

    PC_FE = 32'h148; sb_q.push_back('{32'h14C, 1'b0, exp_br, exp_mis}); #1;
    e = sb_q.pop_front(); n_tests++;
    if ({pcpred_FE, predtaken_FE} !== {e.pred, e.taken}) begin
      n_fail++;
      $display("FAIL reset_clears_branch: got %h/%b, want %h/%b", pcpred_FE, predtaken_FE, e.pred, e.taken);
    end
  endtask

  initial begin
    test_reset;
    test_train;
    test_counter;
    test_alias;
    test_same_cycle;
    test_stats;
    test_reset_with_update;
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
